// File: rtl/hmnoc_pkg.sv
// Shared package for the host sequencer slice.
// Holds the sequencer state encoding and the default job-size constants
// used as parameter defaults by hmnoc_host_seq and its interface.
// Optional feature macro used elsewhere in this slice: HMNOC_HOST_TIMEOUT_EN
// (enables the WAIT_LOAD watchdog in hmnoc_host_seq).
package hmnoc_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LD_WGHT   = 3'd1,
    LD_IACT   = 3'd2,
    SPAD      = 3'd3,
    WAIT_LOAD = 3'd4,
    WAIT_COMP = 3'd5,
    RD_PSUM   = 3'd6,
    FIN       = 3'd7
  } state_t;

  localparam int DEF_DATA_BITWIDTH = 16;
  localparam int DEF_ADDR_BITWIDTH = 10;
  localparam int DEF_NUM_WGHT      = 9;
  localparam int DEF_NUM_IACT      = 25;
  localparam int DEF_NUM_PSUM      = 9;
  localparam int DEF_COMPUTE_WAIT  = 64;
  localparam int DEF_TIMEOUT       = 1024;

  // Width of the internal job counters (word counts, read/pop indices).
  localparam int CNT_W = 16;

endpackage

// File: rtl/hmnoc_host_seq_if.sv
// Bus interface between the host sequencer and its environment (host
// stream, GLB write/read ports, PE cluster control).
//
// Handshake semantics (both host streams): a word transfers on every rising
// clk edge where valid && ready are both 1. The producer holds data stable
// while valid is 1 and ready is 0; valid never depends combinationally on
// ready. in_ready is a pure decode of the sequencer state; out_valid is the
// skid's non-empty flag.
//
// Modports:
//   master - the sequencer (hmnoc_host_seq) side
//   slave  - the host / GLB / PE-cluster side
// fsm_state is a debug copy of the sequencer state for checkers.
interface hmnoc_host_seq_if
  import hmnoc_pkg::*;
#(
  parameter int DATA_BITWIDTH = DEF_DATA_BITWIDTH,
  parameter int ADDR_BITWIDTH = DEF_ADDR_BITWIDTH
);

  logic                     go;
  logic                     busy;
  logic                     done;
  logic                     err;

  logic [DATA_BITWIDTH-1:0] in_data;
  logic                     in_valid;
  logic                     in_ready;

  logic [DATA_BITWIDTH-1:0] out_data;
  logic                     out_valid;
  logic                     out_ready;

  logic                     write_en_wght;
  logic [ADDR_BITWIDTH-1:0] w_addr_wght;
  logic [DATA_BITWIDTH-1:0] w_data_wght;
  logic                     write_en_iact;
  logic [ADDR_BITWIDTH-1:0] w_addr_iact;
  logic [DATA_BITWIDTH-1:0] w_data_iact;

  logic                     load_spad_ctrl_wght;
  logic                     load_spad_ctrl_iact;
  logic                     start;
  logic                     load_done;

  logic                     read_req_psum;
  logic [ADDR_BITWIDTH-1:0] r_addr_psum;
  logic [DATA_BITWIDTH-1:0] r_data_psum;

  state_t                   fsm_state;

  modport master (
    input  go, in_data, in_valid, out_ready, load_done, r_data_psum,
    output busy, done, err, in_ready, out_data, out_valid,
           write_en_wght, w_addr_wght, w_data_wght,
           write_en_iact, w_addr_iact, w_data_iact,
           load_spad_ctrl_wght, load_spad_ctrl_iact, start,
           read_req_psum, r_addr_psum, fsm_state
  );

  modport slave (
    output go, in_data, in_valid, out_ready, load_done, r_data_psum,
    input  busy, done, err, in_ready, out_data, out_valid,
           write_en_wght, w_addr_wght, w_data_wght,
           write_en_iact, w_addr_iact, w_data_iact,
           load_spad_ctrl_wght, load_spad_ctrl_iact, start,
           read_req_psum, r_addr_psum, fsm_state
  );

endinterface

// File: rtl/hmnoc_rd_skid.sv
// Two-entry FIFO that buffers psum words returned by the GLB until the
// host accepts them.
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   push, push_data   - write one word (caller guarantees occ < 2)
//   pop               - remove the head word (caller guarantees occ > 0)
//   out_data          - head word
//   out_valid         - buffer non-empty
//   occ               - current occupancy, 0..2
module hmnoc_rd_skid #(
  parameter int DATA_BITWIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_BITWIDTH-1:0] push_data,
  input  logic                     pop,
  output logic [DATA_BITWIDTH-1:0] out_data,
  output logic                     out_valid,
  output logic [1:0]               occ
);

  logic [DATA_BITWIDTH-1:0] mem [2];
  logic                     wr_ptr;
  logic                     rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign out_data  = mem[rd_ptr];
  assign out_valid = (occ != 2'd0);

endmodule

// File: rtl/hmnoc_host_seq.sv
// Host-side job sequencer for the PE cluster.
// A job: accept NUM_WGHT weight words then NUM_IACT activation words from
// the host stream and write them to the weight/activation GLBs, pulse the
// spad loads and PE start, wait for load_done, wait COMPUTE_WAIT cycles,
// then read NUM_PSUM psum words from the GLB and stream them back to the
// host through a 2-entry skid (hmnoc_rd_skid), and finally pulse done.
// Ports:
//   clk   - clock
//   reset - asynchronous active-high reset
//   bus   - hmnoc_host_seq_if.master (host streams, GLB ports, PE control,
//           status and debug state)
// Optional feature: define HMNOC_HOST_TIMEOUT_EN to enable a watchdog that
// aborts a WAIT_LOAD lasting TIMEOUT cycles with a one-cycle err pulse.
// Without it err is tied to 0 and WAIT_LOAD waits indefinitely.
module hmnoc_host_seq
  import hmnoc_pkg::*;
#(
  parameter int DATA_BITWIDTH = DEF_DATA_BITWIDTH,
  parameter int ADDR_BITWIDTH = DEF_ADDR_BITWIDTH,
  parameter int NUM_WGHT      = DEF_NUM_WGHT,
  parameter int NUM_IACT      = DEF_NUM_IACT,
  parameter int NUM_PSUM      = DEF_NUM_PSUM,
  parameter int W_BASE        = 0,
  parameter int A_BASE        = 0,
  parameter int P_BASE        = 0,
  parameter int COMPUTE_WAIT  = DEF_COMPUTE_WAIT,
  parameter int TIMEOUT       = DEF_TIMEOUT
) (
  input logic              clk,
  input logic              reset,
  hmnoc_host_seq_if.master bus
);

  state_t                   state;
  logic [CNT_W-1:0]         cnt;       // words accepted in the current load phase
  logic [CNT_W-1:0]         rd_idx;    // psum reads issued
  logic [CNT_W-1:0]         pop_cnt;   // psum words delivered to the host
  logic [31:0]              wait_cnt;
  logic                     rd_inflight;

  logic                     write_en_wght_q;
  logic [ADDR_BITWIDTH-1:0] w_addr_wght_q;
  logic [DATA_BITWIDTH-1:0] w_data_wght_q;
  logic                     write_en_iact_q;
  logic [ADDR_BITWIDTH-1:0] w_addr_iact_q;
  logic [DATA_BITWIDTH-1:0] w_data_iact_q;

  logic                     skid_valid;
  logic [1:0]               skid_occ;
  logic [1:0]               rd_pending;
  logic                     read_req;
  logic                     accept;
  logic                     pop;

`ifdef HMNOC_HOST_TIMEOUT_EN
  logic [31:0]              to_cnt;
  logic                     err_q;
`endif

  assign accept = bus.in_valid && bus.in_ready;
  assign pop    = skid_valid && bus.out_ready;

  // Credit check: a word already in the skid or one whose read data arrives
  // next cycle both consume a slot, so never more than 2 are outstanding.
  assign rd_pending = skid_occ + {1'b0, rd_inflight};
  assign read_req   = (state == RD_PSUM) && (rd_pending < 2'd2) &&
                      (rd_idx < CNT_W'(NUM_PSUM));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      rd_idx          <= '0;
      pop_cnt         <= '0;
      wait_cnt        <= '0;
      rd_inflight     <= 1'b0;
      write_en_wght_q <= 1'b0;
      w_addr_wght_q   <= '0;
      w_data_wght_q   <= '0;
      write_en_iact_q <= 1'b0;
      w_addr_iact_q   <= '0;
      w_data_iact_q   <= '0;
`ifdef HMNOC_HOST_TIMEOUT_EN
      to_cnt          <= '0;
      err_q           <= 1'b0;
`endif
    end else begin
      write_en_wght_q <= 1'b0;
      write_en_iact_q <= 1'b0;
      rd_inflight     <= read_req;
`ifdef HMNOC_HOST_TIMEOUT_EN
      err_q           <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus.go) begin
            state   <= LD_WGHT;
            cnt     <= '0;
            rd_idx  <= '0;
            pop_cnt <= '0;
          end
        end

        LD_WGHT: begin
          if (accept) begin
            write_en_wght_q <= 1'b1;
            w_addr_wght_q   <= ADDR_BITWIDTH'(W_BASE) + ADDR_BITWIDTH'(cnt);
            w_data_wght_q   <= bus.in_data;
            if (cnt == CNT_W'(NUM_WGHT - 1)) begin
              cnt   <= '0;
              state <= LD_IACT;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        LD_IACT: begin
          if (accept) begin
            write_en_iact_q <= 1'b1;
            w_addr_iact_q   <= ADDR_BITWIDTH'(A_BASE) + ADDR_BITWIDTH'(cnt);
            w_data_iact_q   <= bus.in_data;
            if (cnt == CNT_W'(NUM_IACT - 1)) begin
              cnt   <= '0;
              state <= SPAD;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        SPAD: begin
          state <= WAIT_LOAD;
`ifdef HMNOC_HOST_TIMEOUT_EN
          to_cnt <= '0;
`endif
        end

        WAIT_LOAD: begin
          if (bus.load_done) begin
            // The load_done cycle counts as the first of the COMPUTE_WAIT
            // cycles, so the first read request lands COMPUTE_WAIT cycles
            // after load_done.
            wait_cnt <= 32'd1;
            state    <= (COMPUTE_WAIT <= 1) ? RD_PSUM : WAIT_COMP;
          end
`ifdef HMNOC_HOST_TIMEOUT_EN
          else if (to_cnt == 32'(TIMEOUT - 1)) begin
            state <= IDLE;
            err_q <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 32'd1;
          end
`endif
        end

        WAIT_COMP: begin
          if (wait_cnt >= 32'(COMPUTE_WAIT - 1)) begin
            state <= RD_PSUM;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end

        RD_PSUM: begin
          if (read_req) begin
            rd_idx <= rd_idx + 1'b1;
          end
          if (pop) begin
            if (pop_cnt == CNT_W'(NUM_PSUM - 1)) begin
              state <= FIN;
            end else begin
              pop_cnt <= pop_cnt + 1'b1;
            end
          end
        end

        FIN: begin
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Read data arrives the cycle after the request; rd_inflight marks it.
  hmnoc_rd_skid #(
    .DATA_BITWIDTH(DATA_BITWIDTH)
  ) u_rd_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (rd_inflight),
    .push_data (bus.r_data_psum),
    .pop       (pop),
    .out_data  (bus.out_data),
    .out_valid (skid_valid),
    .occ       (skid_occ)
  );

  // Control outputs are decodes of the registered state only.
  assign bus.in_ready            = (state == LD_WGHT) || (state == LD_IACT);
  assign bus.busy                = (state != IDLE);
  assign bus.done                = (state == FIN);
  assign bus.load_spad_ctrl_wght = (state == SPAD);
  assign bus.load_spad_ctrl_iact = (state == SPAD);
  assign bus.start               = (state == SPAD);
  assign bus.out_valid           = skid_valid;
  assign bus.read_req_psum       = read_req;
  assign bus.r_addr_psum         = ADDR_BITWIDTH'(P_BASE) + ADDR_BITWIDTH'(rd_idx);

  assign bus.write_en_wght = write_en_wght_q;
  assign bus.w_addr_wght   = w_addr_wght_q;
  assign bus.w_data_wght   = w_data_wght_q;
  assign bus.write_en_iact = write_en_iact_q;
  assign bus.w_addr_iact   = w_addr_iact_q;
  assign bus.w_data_iact   = w_data_iact_q;

  assign bus.fsm_state = state;

`ifdef HMNOC_HOST_TIMEOUT_EN
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_hmnoc_host_seq.sv
// Self-checking bench for hmnoc_host_seq: directed jobs with a table of
// expected GLB writes, a GLB model returning 100+addr, an out_ready pattern
// of 1,0,0,1, reset mid-load, go during RD_PSUM and the WAIT_LOAD watchdog
// (or its absence when HMNOC_HOST_TIMEOUT_EN is undefined).
module tb_hmnoc_host_seq;
  import hmnoc_pkg::*;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int NW = 9;
  localparam int NI = 25;
  localparam int NP = 9;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hmnoc_host_seq_if #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW)) bus();

  hmnoc_host_seq #(
    .DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW),
    .NUM_WGHT(NW), .NUM_IACT(NI), .NUM_PSUM(NP),
    .W_BASE(0), .A_BASE(0), .P_BASE(0),
    .COMPUTE_WAIT(64), .TIMEOUT(1024)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic          bank;   // 0 = weight GLB, 1 = activation GLB
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_vec_t;
  wr_vec_t wr_tbl [NW+NI];

  typedef struct {
    string       name;
    logic [31:0] got;
  } sig_rec_t;

  logic [DW+AW:0] wr_q [$];
  logic [DW-1:0]  got_q [$];
  logic [DW-1:0]  exp_q [$];
  int  last_hs_cyc, spad_cyc, spad_cnt, spad_bad, ld_cyc;
  int  first_rd_cyc, first_rd_addr, rd_cnt, rd_addr_bad;
  int  done_cnt, err_cnt, err_cyc;
  logic err_busy;

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_records();
    wr_q.delete(); got_q.delete(); exp_q.delete();
    last_hs_cyc = -1; spad_cyc = -1; spad_cnt = 0; spad_bad = 0; ld_cyc = -1;
    first_rd_cyc = -1; first_rd_addr = -1; rd_cnt = 0; rd_addr_bad = 0;
    done_cnt = 0; err_cnt = 0; err_cyc = -1; err_busy = 1'b0;
  endtask

  // ---------------- monitor (samples on the falling edge) ----------------
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (bus.in_valid && bus.in_ready) last_hs_cyc = cyc;
      if (bus.write_en_wght) wr_q.push_back({1'b0, bus.w_addr_wght, bus.w_data_wght});
      if (bus.write_en_iact) wr_q.push_back({1'b1, bus.w_addr_iact, bus.w_data_iact});
      if (bus.start || bus.load_spad_ctrl_wght || bus.load_spad_ctrl_iact) begin
        spad_cnt++;
        spad_cyc = cyc;
        if (!(bus.start && bus.load_spad_ctrl_wght && bus.load_spad_ctrl_iact)) spad_bad++;
      end
      if (bus.load_done && bus.fsm_state == WAIT_LOAD && ld_cyc < 0) ld_cyc = cyc;
      if (bus.read_req_psum) begin
        if (first_rd_cyc < 0) begin
          first_rd_cyc  = cyc;
          first_rd_addr = int'(bus.r_addr_psum);
        end
        if (int'(bus.r_addr_psum) != rd_cnt) rd_addr_bad++;
        rd_cnt++;
      end
      if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
      if (bus.done) done_cnt++;
      if (bus.err) begin
        err_cnt++;
        err_cyc  = cyc;
        err_busy = bus.busy;
      end
    end
  end

  // ---------------- GLB psum model: data = 100 + addr, one cycle later ----
  logic          pend_v = 1'b0;
  logic [AW-1:0] pend_a = '0;
  initial forever begin
    @(negedge clk);
    pend_v = bus.read_req_psum;
    pend_a = bus.r_addr_psum;
  end
  initial begin
    bus.r_data_psum = 16'hDEAD;
    forever begin
      @(posedge clk);
      #1;
      bus.r_data_psum = pend_v ? DW'(100 + int'(pend_a)) : 16'hDEAD;
    end
  end

  // ---------------- host out_ready pattern 1,0,0,1 ----------------
  logic rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  int   rdy_i = 0;
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rdy_pat[rdy_i % 4];
      rdy_i++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_go();
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
  endtask

  task automatic feed_words(input int n, input int first);
    int w;
    for (int k = 0; k < n; k++) begin
      bus.in_data  = DW'(first + k);
      bus.in_valid = 1'b1;
      w = 0;
      while (!bus.in_ready && w < 50) begin
        tick();
        w++;
      end
      if (w >= 50) begin
        check($sformatf("in_ready_wait[%0d]", k), bus.in_ready, 1);
        break;
      end
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    sig_rec_t recs [13];
    recs[0]  = '{"busy",          32'(bus.busy)};
    recs[1]  = '{"in_ready",      32'(bus.in_ready)};
    recs[2]  = '{"out_valid",     32'(bus.out_valid)};
    recs[3]  = '{"done",          32'(bus.done)};
    recs[4]  = '{"err",           32'(bus.err)};
    recs[5]  = '{"write_en_wght", 32'(bus.write_en_wght)};
    recs[6]  = '{"write_en_iact", 32'(bus.write_en_iact)};
    recs[7]  = '{"read_req_psum", 32'(bus.read_req_psum)};
    recs[8]  = '{"start",         32'(bus.start)};
    recs[9]  = '{"load_spad_w",   32'(bus.load_spad_ctrl_wght)};
    recs[10] = '{"load_spad_i",   32'(bus.load_spad_ctrl_iact)};
    recs[11] = '{"w_addr_iact",   32'(bus.w_addr_iact)};
    recs[12] = '{"r_addr_psum",   32'(bus.r_addr_psum)};
    for (int i = 0; i < 13; i++) check({tag, ".", recs[i].name}, recs[i].got, 0);
  endtask

  // Wait for the SPAD pulse; returns with the bench in the cycle after it.
  task automatic wait_spad();
    int w = 0;
    while (spad_cnt == 0 && w < 60) begin
      tick();
      w++;
    end
    check("spad_seen", spad_cnt, 1);
  endtask

  task automatic run_job(input string tag, input bit go_in_rd);
    int w;
    logic [DW+AW:0] g;
    logic [DW-1:0]  gd;
    logic [DW-1:0]  e;
    clear_records();
    for (int i = 0; i < NP; i++) exp_q.push_back(DW'(100 + i));
    pulse_go();
    feed_words(NW + NI, 1);
    wait_spad();
    repeat (4) tick();
    bus.load_done = 1'b1;       // during the 5th cycle after start
    tick();
    bus.load_done = 1'b0;
    if (go_in_rd) begin
      w = 0;
      while (bus.fsm_state != RD_PSUM && w < 100) begin
        tick();
        w++;
      end
      check({tag, ".in_rd_psum"}, int'(bus.fsm_state), int'(RD_PSUM));
      tick();
      bus.go = 1'b1;
      tick();
      bus.go = 1'b0;
    end
    w = 0;
    while (done_cnt == 0 && w < 300) begin
      tick();
      w++;
    end
    repeat (3) tick();

    check({tag, ".wr_count"}, wr_q.size(), NW + NI);
    for (int i = 0; i < NW + NI; i++) begin
      g = (i < wr_q.size()) ? wr_q[i] : '1;
      check($sformatf("%s.wr[%0d]", tag, i), g,
            {wr_tbl[i].bank, wr_tbl[i].addr, wr_tbl[i].data});
    end
    check({tag, ".spad_cnt"}, spad_cnt, 1);
    check({tag, ".spad_together"}, spad_bad, 0);
    check({tag, ".spad_after_last_word"}, spad_cyc, last_hs_cyc + 1);
    check({tag, ".load_done_cycle"}, ld_cyc, spad_cyc + 5);
    check({tag, ".first_rd_cycle"}, first_rd_cyc, ld_cyc + 64);
    check({tag, ".first_rd_addr"}, first_rd_addr, 0);
    check({tag, ".rd_count"}, rd_cnt, NP);
    check({tag, ".rd_addr_order"}, rd_addr_bad, 0);
    check({tag, ".out_count"}, got_q.size(), NP);
    for (int i = 0; i < NP; i++) begin
      gd = (got_q.size() > 0) ? got_q.pop_front() : 16'hFFFF;
      e  = exp_q.pop_front();
      check($sformatf("%s.out[%0d]", tag, i), gd, e);
    end
    check({tag, ".done_cnt"}, done_cnt, 1);
    check({tag, ".err_cnt"}, err_cnt, 0);
    check({tag, ".busy_after"}, bus.busy, 0);
    check({tag, ".state_after"}, int'(bus.fsm_state), int'(IDLE));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    for (int k = 0; k < NW; k++) wr_tbl[k] = '{1'b0, AW'(k), DW'(k + 1)};
    for (int k = 0; k < NI; k++) wr_tbl[NW + k] = '{1'b1, AW'(k), DW'(NW + 1 + k)};

    bus.go = 1'b0; bus.in_data = '0; bus.in_valid = 1'b0; bus.load_done = 1'b0;
    clear_records();
    reset = 1'b1;
    repeat (3) tick();
    check_quiet("reset");
    bus.go = 1'b1;              // go coincident with reset release
    reset = 1'b0;
    @(negedge clk);
    check("post_reset.write_en_wght", bus.write_en_wght, 0);
    check("post_reset.write_en_iact", bus.write_en_iact, 0);
    check("post_reset.read_req_psum", bus.read_req_psum, 0);
    @(posedge clk);
    #1;
    bus.go = 1'b0;
    check("go_starts_job", int'(bus.fsm_state), int'(LD_WGHT));
    reset = 1'b1;               // back to a clean idle
    tick();
    reset = 1'b0;
    tick();

    run_job("job1", 1'b0);

    // Reset in the middle of the activation load.
    clear_records();
    pulse_go();
    feed_words(NW + 15, 1);
    check("mid.state", int'(bus.fsm_state), int'(LD_IACT));
    reset = 1'b1;
    #2;
    check_quiet("mid_async");
    tick();
    check_quiet("mid_next");
    reset = 1'b0;
    @(negedge clk);
    check("mid_release.write_en_iact", bus.write_en_iact, 0);
    check("mid_release.busy", bus.busy, 0);
    tick();
    run_job("job2", 1'b0);

    run_job("job3_go_in_rd", 1'b1);

    // WAIT_LOAD with load_done never asserted.
    clear_records();
    pulse_go();
    feed_words(NW + NI, 1);
    wait_spad();
`ifdef HMNOC_HOST_TIMEOUT_EN
    begin
      int w = 0;
      while (err_cnt == 0 && w < 1200) begin
        tick();
        w++;
      end
    end
    repeat (3) tick();
    check("wd.err_cnt", err_cnt, 1);
    check("wd.err_cycle", err_cyc, spad_cyc + 1025);
    check("wd.busy_at_err", err_busy, 0);
    check("wd.done_cnt", done_cnt, 0);
    check("wd.state", int'(bus.fsm_state), int'(IDLE));
`else
    repeat (1100) tick();
    check("wd.err_cnt", err_cnt, 0);
    check("wd.busy", bus.busy, 1);
    check("wd.state", int'(bus.fsm_state), int'(WAIT_LOAD));
    check("wd.done_cnt", done_cnt, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
